// File: rtl/mem_rd_ctrl_pkg.sv
// Shared definitions for the multi-cycle memory read controller:
// state encodings and the latency-counter width rule.
package mem_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Counter must be able to hold the value LATENCY itself.
  function automatic int cnt_width(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/mem_rd_cnt.sv
// Clearable, enabled up-counter with a terminal-count flag (cnt == LATENCY).
module mem_rd_cnt
  import mem_rd_ctrl_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int CW      = cnt_width(LATENCY)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == CW'(LATENCY));

endmodule

// File: rtl/mem_rd_ctrl.sv
// Multi-cycle read controller: strobes a variable-latency memory, stalls the
// pipeline while the access is outstanding and presents the result for one cycle.
module mem_rd_ctrl
  import mem_rd_ctrl_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          stall,
  output logic [DW-1:0] rd_data,
  output logic          rd_done,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  input  logic          mem_valid,
  output logic          err
);

  localparam int CW = cnt_width(LATENCY);

  state_e        state_q, state_d;
  logic          mem_rd_q, mem_rd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_done_q, rd_done_d;
  logic          err_q, err_d;
  logic          cnt_clr, cnt_en, cnt_tc;
  logic [CW-1:0] cnt;

  mem_rd_cnt #(
    .LATENCY(LATENCY),
    .CW     (CW)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (cnt_en),
    .cnt(cnt),
    .tc (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    rd_data_d  = rd_data_q;
    rd_done_d  = 1'b0;
    err_d      = err_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    stall      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stall = rd_req;
        if (rd_req) begin
          state_d    = ST_WAIT;
          mem_rd_d   = 1'b1;
          mem_addr_d = rd_addr;
          cnt_clr    = 1'b1;
        end
        if (mem_valid) begin
          err_d = 1'b1;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        // A response in the strobe cycle itself is illegal; keep waiting.
        if (mem_valid) begin
          if (cnt == '0) begin
            err_d = 1'b1;
          end else begin
            rd_data_d = mem_data;
            rd_done_d = 1'b1;
            state_d   = ST_DONE;
          end
        end else if (cnt_tc) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
        cnt_en = (state_d == ST_WAIT);
      end
      ST_DONE: begin
        // rd_req here still belongs to the instruction now advancing.
        state_d = ST_IDLE;
        if (mem_valid) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (rst) begin
      stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      rd_data_q  <= '0;
      rd_done_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      rd_data_q  <= rd_data_d;
      rd_done_q  <= rd_done_d;
      err_q      <= err_d;
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign rd_data  = rd_data_q;
  assign rd_done  = rd_done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_rd_ctrl.sv
// Directed, table-driven bench for mem_rd_ctrl (LATENCY=4): one record per
// clock cycle holding the inputs and the outputs expected during that cycle.
module tb_mem_rd_ctrl;

  logic        clk;
  logic        rst;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        stall;
  logic [15:0] rd_data;
  logic        rd_done;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic        err;

  int checks   = 0;
  int failures = 0;

  mem_rd_ctrl #(
    .LATENCY(4),
    .AW     (16),
    .DW     (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .stall    (stall),
    .rd_data  (rd_data),
    .rd_done  (rd_done),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_valid(mem_valid),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        rst;
    logic        req;
    logic [15:0] addr;
    logic        mv;
    logic [15:0] mdata;
    logic        x_stall;
    logic        x_done;
    logic        x_mrd;
    logic [15:0] x_addr;
    logic [15:0] x_data;
    logic        x_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string tag, input logic r, input logic q,
                              input logic [15:0] a, input logic v, input logic [15:0] d,
                              input logic s, input logic dn, input logic m,
                              input logic [15:0] ea, input logic [15:0] ed, input logic e);
    vec_t t;
    t.tag = tag; t.rst = r; t.req = q; t.addr = a; t.mv = v; t.mdata = d;
    t.x_stall = s; t.x_done = dn; t.x_mrd = m; t.x_addr = ea; t.x_data = ed; t.x_err = e;
    return t;
  endfunction

  task automatic chk(input string tag, input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s: got %0h, expected %0h", tag, nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst       = v.rst;
    rd_req    = v.req;
    rd_addr   = v.addr;
    mem_valid = v.mv;
    mem_data  = v.mdata;
    @(negedge clk);
    chk(v.tag, "stall",    {15'd0, stall},   {15'd0, v.x_stall});
    chk(v.tag, "rd_done",  {15'd0, rd_done}, {15'd0, v.x_done});
    chk(v.tag, "mem_rd",   {15'd0, mem_rd},  {15'd0, v.x_mrd});
    chk(v.tag, "mem_addr", mem_addr,         v.x_addr);
    chk(v.tag, "rd_data",  rd_data,          v.x_data);
    chk(v.tag, "err",      {15'd0, err},     {15'd0, v.x_err});
    $display("cyc %s: stall=%0b done=%0b mem_rd=%0b mem_addr=%h rd_data=%h err=%0b",
             v.tag, stall, rd_done, mem_rd, mem_addr, rd_data, err);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    rd_req    = 1'($urandom);
    rd_addr   = 16'($urandom);
    mem_valid = 1'($urandom);
    mem_data  = 16'($urandom);
  endtask

  initial begin
    // Nominal max latency: response 4 cycles after the strobe.
    tbl.push_back(mk("a0", 0, 1, 16'h1234, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk("a1", 0, 1, 16'h1234, 0, 16'h0000, 1, 0, 1, 16'h1234, 16'h0000, 0));
    tbl.push_back(mk("a2", 0, 1, 16'h1234, 0, 16'h0000, 1, 0, 0, 16'h1234, 16'h0000, 0));
    tbl.push_back(mk("a3", 0, 1, 16'h1234, 0, 16'h0000, 1, 0, 0, 16'h1234, 16'h0000, 0));
    tbl.push_back(mk("a4", 0, 1, 16'h1234, 0, 16'h0000, 1, 0, 0, 16'h1234, 16'h0000, 0));
    tbl.push_back(mk("a5", 0, 1, 16'h1234, 1, 16'hBEEF, 1, 0, 0, 16'h1234, 16'h0000, 0));
    tbl.push_back(mk("a6", 0, 1, 16'h1234, 0, 16'h0000, 0, 1, 0, 16'h1234, 16'hBEEF, 0));
    tbl.push_back(mk("a7", 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h1234, 16'hBEEF, 0));
    // Fast response, back-to-back request right after DONE.
    tbl.push_back(mk("b0", 0, 1, 16'h2000, 0, 16'h0000, 1, 0, 0, 16'h1234, 16'hBEEF, 0));
    tbl.push_back(mk("b1", 0, 1, 16'h2000, 0, 16'h0000, 1, 0, 1, 16'h2000, 16'hBEEF, 0));
    tbl.push_back(mk("b2", 0, 1, 16'h2000, 1, 16'h00FF, 1, 0, 0, 16'h2000, 16'hBEEF, 0));
    tbl.push_back(mk("b3", 0, 1, 16'h2000, 0, 16'h0000, 0, 1, 0, 16'h2000, 16'h00FF, 0));
    tbl.push_back(mk("b4", 0, 1, 16'h3000, 0, 16'h0000, 1, 0, 0, 16'h2000, 16'h00FF, 0));
    tbl.push_back(mk("b5", 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 1, 16'h3000, 16'h00FF, 0));
    tbl.push_back(mk("b6", 0, 0, 16'h0000, 1, 16'hBEEF, 1, 0, 0, 16'h3000, 16'h00FF, 0));
    tbl.push_back(mk("b7", 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h3000, 16'hBEEF, 0));
    tbl.push_back(mk("b8", 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h3000, 16'hBEEF, 0));
    // Timeout: no response at all.
    tbl.push_back(mk("c0", 0, 1, 16'h4000, 0, 16'h0000, 1, 0, 0, 16'h3000, 16'hBEEF, 0));
    tbl.push_back(mk("c1", 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 1, 16'h4000, 16'hBEEF, 0));
    tbl.push_back(mk("c2", 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h4000, 16'hBEEF, 0));
    tbl.push_back(mk("c3", 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h4000, 16'hBEEF, 0));
    tbl.push_back(mk("c4", 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h4000, 16'hBEEF, 0));
    tbl.push_back(mk("c5", 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h4000, 16'hBEEF, 0));
    tbl.push_back(mk("c6", 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h4000, 16'hBEEF, 1));
    tbl.push_back(mk("c7", 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h4000, 16'hBEEF, 1));
    // Reset in the middle of WAIT, then a stray response.
    tbl.push_back(mk("d0", 0, 1, 16'h5000, 0, 16'h0000, 1, 0, 0, 16'h4000, 16'hBEEF, 1));
    tbl.push_back(mk("d1", 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 1, 16'h5000, 16'hBEEF, 1));
    tbl.push_back(mk("d2", 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h5000, 16'hBEEF, 1));
    tbl.push_back(mk("d3", 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h5000, 16'hBEEF, 1));
    tbl.push_back(mk("d4", 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk("d5", 0, 0, 16'h0000, 1, 16'h7777, 0, 0, 0, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk("d6", 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1));
    // Spurious response in IDLE must not touch rd_data.
    tbl.push_back(mk("er", 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1));
    tbl.push_back(mk("e0", 0, 1, 16'h6000, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk("e1", 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 1, 16'h6000, 16'h0000, 0));
    tbl.push_back(mk("e2", 0, 0, 16'h0000, 1, 16'h5555, 1, 0, 0, 16'h6000, 16'h0000, 0));
    tbl.push_back(mk("e3", 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h6000, 16'h5555, 0));
    tbl.push_back(mk("e4", 0, 0, 16'h0000, 1, 16'hAAAA, 0, 0, 0, 16'h6000, 16'h5555, 0));
    tbl.push_back(mk("e5", 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h6000, 16'h5555, 1));
    // Same-cycle (cnt=0) response is an error; a later legal one completes.
    tbl.push_back(mk("fr", 1, 1, 16'h9999, 0, 16'h0000, 0, 0, 0, 16'h6000, 16'h5555, 1));
    tbl.push_back(mk("f0", 0, 1, 16'h7000, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk("f1", 0, 0, 16'h0000, 1, 16'h1111, 1, 0, 1, 16'h7000, 16'h0000, 0));
    tbl.push_back(mk("f2", 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h7000, 16'h0000, 1));
    tbl.push_back(mk("f3", 0, 0, 16'h0000, 1, 16'h2222, 1, 0, 0, 16'h7000, 16'h0000, 1));
    tbl.push_back(mk("f4", 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h7000, 16'h2222, 1));
    tbl.push_back(mk("f5", 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h7000, 16'h2222, 1));

    // Two reset cycles with random inputs: stall must stay low throughout.
    rst = 1'b1;
    rand_inputs();
    @(negedge clk);
    chk("rst0", "stall", {15'd0, stall}, 16'd0);
    $display("cyc rst0: stall=%0b", stall);
    @(posedge clk);
    #1;
    rand_inputs();
    @(negedge clk);
    chk("rst1", "stall",    {15'd0, stall},   16'd0);
    chk("rst1", "rd_done",  {15'd0, rd_done}, 16'd0);
    chk("rst1", "mem_rd",   {15'd0, mem_rd},  16'd0);
    chk("rst1", "mem_addr", mem_addr,         16'd0);
    chk("rst1", "rd_data",  rd_data,          16'd0);
    chk("rst1", "err",      {15'd0, err},     16'd0);
    $display("cyc rst1: stall=%0b done=%0b mem_rd=%0b mem_addr=%h rd_data=%h err=%0b",
             stall, rd_done, mem_rd, mem_addr, rd_data, err);
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      apply(tbl[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
